// File: rtl/add_sub_mod_pipe.sv
// Two-stage pipelined modular add/subtract with tag sideband, range flag and valid/ready flow control.
// Stage 1 forms the raw sum/difference; stage 2 applies a single modulus correction.
module add_sub_mod_pipe #(
    parameter int DATA_WIDTH = 192,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sub,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    input  logic [DATA_WIDTH-1:0] opM,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_err
);

    logic                  s2_en;
    logic                  s1_en;
    logic                  accept;

    logic                  s1_valid;
    logic [DATA_WIDTH:0]   s1_raw;
    logic [DATA_WIDTH-1:0] s1_mod;
    logic                  s1_sub;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic                  s1_err;

    logic [DATA_WIDTH:0]   raw_in;
    logic                  err_in;
    logic [DATA_WIDTH-1:0] add_red;
    logic [DATA_WIDTH-1:0] sub_fix;
    logic [DATA_WIDTH-1:0] res;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign accept   = in_valid && in_ready;

    // One extra bit keeps the carry (add) or the borrow (sub) of the raw result.
    assign raw_in = in_sub ? ({1'b0, opA} - {1'b0, opB})
                           : ({1'b0, opA} + {1'b0, opB});
    assign err_in = (opA >= opM) || (opB >= opM);

    // raw < 2*mod whenever raw >= mod in add mode, so the low bits of raw-mod are exact.
    assign add_red = s1_raw[DATA_WIDTH-1:0] - s1_mod;
    assign sub_fix = s1_raw[DATA_WIDTH-1:0] + s1_mod;

    always_comb begin
        res = s1_raw[DATA_WIDTH-1:0];
        if (s1_sub) begin
            if (s1_raw[DATA_WIDTH]) begin
                res = sub_fix;
            end
        end else if (s1_raw >= {1'b0, s1_mod}) begin
            res = add_red;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_raw    <= '0;
            s1_mod    <= '0;
            s1_sub    <= 1'b0;
            s1_tag    <= '0;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_raw <= raw_in;
                s1_mod <= opM;
                s1_sub <= in_sub;
                s1_tag <= in_tag;
                s1_err <= err_in;
            end
            if (s2_en) begin
                out_valid <= s1_valid;
            end
            if (s2_en && s1_valid) begin
                out_data <= res;
                out_tag  <= s1_tag;
                out_err  <= s1_err;
            end
        end
    end

endmodule
